// File: rtl/uart_command_decoder.sv
// uart_command_decoder
//   Decodes framed commands arriving from the UART receiver and drives the
//   register file port. It also returns read results to the UART transmitter.
//     write frame : WR_CMD, ADDR, DATA  -> write_en pulse, one cycle after DATA
//     read frame  : RD_CMD, ADDR        -> read_en pulse, then one tx byte
//   Only one command is in flight at a time. A byte that cannot be consumed
//   is dropped and raises a one-cycle cmd_error pulse.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   rx_data/_valid        received byte and its one-cycle strobe
//   address, write_en,
//   read_en, write_data   register file request port
//   read_data/_valid      register file read response
//   tx_busy               transmitter busy (back-pressure)
//   tx_data/_valid        response byte and its one-cycle strobe
//   cmd_error             one-cycle protocol error strobe
module uart_command_decoder #(
    parameter int                    DATA_WIDTH          = 8,
    parameter int                    REGISTER_FILE_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] WR_CMD              = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD              = 8'hBB,
    parameter int                    RD_TIMEOUT          = 4,
    localparam int                   ADDRESS_WIDTH       = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_data_valid,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     write_en,
    output logic                     read_en,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     read_data_valid,
    input  logic                     tx_busy,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_data_valid,
    output logic                     cmd_error
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rd_cnt;
    logic             addr_ok;

    // An address byte is legal only when every bit above the register index is zero.
    assign addr_ok = ((rx_data >> ADDRESS_WIDTH) == '0);

    // This output is decoded from the registered state. It therefore fires in the
    // very first non-busy cycle of TX_SEND. That keeps the read latency at 3 cycles
    // after the ADDR strobe, and there is no extra cycle after back-pressure ends.
    assign tx_data_valid = (state == TX_SEND) && !tx_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            address    <= '0;
            write_data <= '0;
            tx_data    <= '0;
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            cmd_error  <= 1'b0;
            rd_cnt     <= '0;
        end else begin
            // Strobes default low, so each one lasts exactly one cycle.
            write_en  <= 1'b0;
            read_en   <= 1'b0;
            cmd_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_data_valid) begin
                        if (rx_data == WR_CMD)      state <= WR_ADDR;
                        else if (rx_data == RD_CMD) state <= RD_ADDR;
                        else                        cmd_error <= 1'b1;
                    end
                end

                WR_ADDR: begin
                    if (rx_data_valid) begin
                        if (addr_ok) begin
                            address <= rx_data[ADDRESS_WIDTH-1:0];
                            state   <= WR_DATA;
                        end else begin
                            cmd_error <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                WR_DATA: begin
                    if (rx_data_valid) begin
                        write_data <= rx_data;
                        write_en   <= 1'b1;     // high for the single WR_EXEC cycle
                        state      <= WR_EXEC;
                    end
                end

                WR_EXEC: begin
                    if (rx_data_valid) cmd_error <= 1'b1;
                    state <= IDLE;
                end

                RD_ADDR: begin
                    if (rx_data_valid) begin
                        if (addr_ok) begin
                            address <= rx_data[ADDRESS_WIDTH-1:0];
                            read_en <= 1'b1;    // high for the first RD_WAIT cycle
                            rd_cnt  <= '0;
                            state   <= RD_WAIT;
                        end else begin
                            cmd_error <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                RD_WAIT: begin
                    if (rx_data_valid) cmd_error <= 1'b1;
                    // rd_cnt is 0 in the read_en cycle. The last cycle that can still
                    // accept data is therefore RD_TIMEOUT-1.
                    if (read_data_valid) begin
                        tx_data <= read_data;
                        state   <= TX_SEND;
                    end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        cmd_error <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end

                TX_SEND: begin
                    if (rx_data_valid) cmd_error <= 1'b1;
                    if (!tx_busy) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_command_decoder.md
Name: uart_command_decoder

Overview:
- Command-decoding FSM that consumes bytes from the UART receiver and drives the register file's address/write_en/read_en/write_data port.
- Returns read results to the UART transmitter.
- Sits between uart_rx (upstream) and register_file (downstream) in the processor UART system.
- Supports two framed commands: a register write and a register read.

Parameters:
- DATA_WIDTH, 8, width of UART bytes and register data.
- REGISTER_FILE_DEPTH, 16, number of registers. ADDRESS_WIDTH = $clog2(REGISTER_FILE_DEPTH).
- WR_CMD, 8'hAA, command byte for write.
- RD_CMD, 8'hBB, command byte for read.
- RD_TIMEOUT, 4, max cycles to wait for read_data_valid after read_en.

Ports:
- clk  in  1  system clock (40 MHz nominal).
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  DATA_WIDTH  received byte.
- rx_data_valid  in  1  one-cycle strobe, rx_data valid.
- address  out  ADDRESS_WIDTH  register file address.
- write_en  out  1  register file write strobe.
- read_en  out  1  register file read strobe.
- write_data  out  DATA_WIDTH  register file write data.
- read_data  in  DATA_WIDTH  register file read data.
- read_data_valid  in  1  register file read data valid.
- tx_busy  in  1  transmitter busy; no new byte accepted while high.
- tx_data  out  DATA_WIDTH  byte to transmit.
- tx_data_valid  out  1  one-cycle strobe, tx_data valid.
- cmd_error  out  1  one-cycle strobe on protocol error.

Behaviour:
- Reset: all outputs 0 (address, write_data, tx_data = 0; all strobes low); state IDLE. Reset is asynchronous and takes effect at any point, including mid-frame; a partial frame is discarded and no write_en/read_en is issued.
- Frames:
  - Write: WR_CMD, ADDR, DATA.
  - Read: RD_CMD, ADDR. Its response is one tx byte.
  - Bytes are consumed only on cycles with rx_data_valid=1; there is no inter-byte timeout.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - rx byte == WR_CMD goes to WR_ADDR.
  - rx byte == RD_CMD goes to RD_ADDR.
  - Any other byte: cmd_error pulse, stay in IDLE.
- WR_ADDR / RD_ADDR:
  - Byte bits [DATA_WIDTH-1:ADDRESS_WIDTH] must be 0. If not: cmd_error pulse, go to IDLE, no register access.
  - Otherwise latch address[ADDRESS_WIDTH-1:0].
  - WR_ADDR then goes to WR_DATA. RD_ADDR goes to RD_WAIT and drives read_en=1 for exactly the first cycle of RD_WAIT (the cycle after the ADDR strobe).
- WR_DATA: latch write_data, then go to WR_EXEC.
- WR_EXEC (one cycle): write_en=1 for exactly this cycle, the cycle after the DATA strobe. address and write_data are held stable during it. Then go to IDLE.
- RD_WAIT:
  - The register file returns read_data_valid one cycle after read_en.
  - On read_data_valid=1: latch tx_data=read_data, go to TX_SEND.
  - If not seen within RD_TIMEOUT cycles after read_en (counter starts at read_en cycle): cmd_error pulse, go to IDLE.
- TX_SEND: while tx_busy=1, wait. On the first cycle with tx_busy=0, pulse tx_data_valid for one cycle, then go to IDLE.
- Bytes arriving in WR_EXEC, RD_WAIT or TX_SEND are dropped with a cmd_error pulse; the FSM is unaffected.
- address, write_data and tx_data hold their last value between commands.
- write_en and read_en are never high in the same cycle.
- Only one command is in flight; there is no pipelining.
- Latency:
  - Write: write_en one cycle after the DATA strobe.
  - Read: tx_data_valid 3 cycles after the ADDR strobe (read_en +1, read_data_valid +1, tx_data_valid +1) when tx_busy=0.

Test Plan:
- Reset mid-frame: send AA, 03, then assert reset_n=0 before DATA -> all outputs 0, no write_en; after release, AA,03,5C -> write_en single cycle with address=3, write_data=8'h5C.
- Write then read: AA,0E,F4 then BB,0E -> tx_data_valid pulse with tx_data=8'hF4 exactly 3 cycles after the ADDR strobe; register file read_data_valid seen one cycle after read_en.
- Bad command: byte 8'h12 in IDLE -> cmd_error one-cycle pulse, no write_en/read_en, FSM accepts AA next.
- Address out of range: AA,10 (bit 4 set, depth 16) -> cmd_error pulse, return to IDLE, following byte 3C treated as command (error again), register file unchanged.
- TX back-pressure: tx_busy=1 held 10 cycles during BB,02 read of 8'h77 -> tx_data_valid stays low, then a single pulse with tx_data=8'h77 on the first tx_busy=0 cycle; an rx byte injected meanwhile -> cmd_error pulse, response still correct.
- Read timeout: stub read_data_valid stuck at 0, BB,01 -> cmd_error 4 cycles after read_en, no tx_data_valid, FSM back in IDLE.
